mult_rr_arbiter: RTL and testbench

MULT_RR_ARBITER -- requirements
Module: mult_rr_arbiter

---
 rtl/mult_arb_pkg.sv | 18 +
 rtl/mult_tag_pipe.sv | 46 ++++
 rtl/mult_rr_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mult_rr_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_arb_pkg.sv
// Purpose : shared constants and the response tag type for the multiplier arbiter.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package mult_arb_pkg;

    localparam int MAX_REQ = 4;   // largest supported requester count
    localparam int ID_W    = 2;   // requester id width, covers MAX_REQ
    localparam int OPND_W  = 4;   // multiplier operand width
    localparam int PROD_W  = 8;   // multiplier product width (15*15=225 fits)

    // One slot of the tag delay line: which requester owns the result
    // emerging from the multiplier, and whether there is a result at all.
    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/mult_tag_pipe.sv
// Purpose : fixed-depth delay line carrying response tags alongside the multiplier.
// Latency : DEPTH cycles from in_tag to out_tag.
// Backpressure: none; shifts every cycle.
//
// Ports: clk, rst (sync, active-high), clr (drops valid on every stage),
//        in_tag (pushed each cycle), out_tag (oldest stage).
module mult_tag_pipe
    import mult_arb_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  tag_t in_tag,
    output tag_t out_tag
);

    tag_t [DEPTH-1:0] stage_q;
    tag_t [DEPTH-1:0] stage_d;

    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = in_tag;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
        // Clearing only the valid bits is enough to kill every in-flight result.
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_d[i].valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign out_tag = stage_q[DEPTH-1];

endmodule

// File: rtl/mult_rr_arbiter.sv
// Purpose : shares one external pipelined 4x4 multiplier among N_REQ requesters.
// Latency : accept in cycle t -> rsp_valid/rsp_product in cycle t+1+LAT.
// Backpressure: none; one request may be accepted every cycle, flush blocks grants.
//
// Ports: clk, rst (sync, active-high), flush, req_valid/req_a/req_b (packed per
//        requester), req_grant (combinational one-hot), mul_a/mul_b (registered
//        operands out), mul_product (multiplier result in), rsp_valid (one-hot
//        strobe), rsp_product (pass-through of mul_product).
// Build option: define MULT_ARB_FIXED_PRIO_EN for fixed lowest-index-wins
//        priority instead of round robin; ports and latency are unchanged.
module mult_rr_arbiter
    import mult_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int LAT   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [OPND_W*N_REQ-1:0]    req_a,
    input  logic [OPND_W*N_REQ-1:0]    req_b,
    output logic [N_REQ-1:0]           req_grant,
    output logic [OPND_W-1:0]          mul_a,
    output logic [OPND_W-1:0]          mul_b,
    input  logic [PROD_W-1:0]          mul_product,
    output logic [N_REQ-1:0]           rsp_valid,
    output logic [PROD_W-1:0]          rsp_product
);

    logic [ID_W-1:0]   win_id;
    logic              accept;
    logic [OPND_W-1:0] sel_a;
    logic [OPND_W-1:0] sel_b;
    logic [OPND_W-1:0] mul_a_q;
    logic [OPND_W-1:0] mul_a_d;
    logic [OPND_W-1:0] mul_b_q;
    logic [OPND_W-1:0] mul_b_d;
    tag_t              tag_in;
    tag_t              tag_out;

`ifdef MULT_ARB_FIXED_PRIO_EN
    // Lowest-numbered valid requester wins; scanning downward lets the
    // last hit be the lowest index.
    always_comb begin
        win_id = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                win_id = ID_W'(i);
            end
        end
    end
`else
    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] ptr_d;
    logic [ID_W-1:0] hi_id;
    logic [ID_W-1:0] lo_id;
    logic            hi_found;

    // Round robin without modular arithmetic: the lowest valid index at or
    // above ptr wins; if none exists the search has wrapped, so the lowest
    // valid index overall wins.
    always_comb begin
        hi_id    = '0;
        lo_id    = '0;
        hi_found = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_id = ID_W'(i);
                if (ID_W'(i) >= ptr_q) begin
                    hi_id    = ID_W'(i);
                    hi_found = 1'b1;
                end
            end
        end
        win_id = hi_found ? hi_id : lo_id;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = (win_id == ID_W'(N_REQ - 1)) ? '0 : win_id + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // Flush and reset both suppress the grant; the request simply stays pending.
    assign accept = (|req_valid) && !flush && !rst;

    always_comb begin
        req_grant = '0;
        sel_a     = '0;
        sel_b     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_id == ID_W'(i)) begin
                req_grant[i] = accept;
                sel_a        = req_a[OPND_W*i +: OPND_W];
                sel_b        = req_b[OPND_W*i +: OPND_W];
            end
        end
    end

    always_comb begin
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        if (accept) begin
            mul_a_d = sel_a;
            mul_b_d = sel_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mul_a_q <= '0;
            mul_b_q <= '0;
        end else begin
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
        end
    end

    assign mul_a = mul_a_q;
    assign mul_b = mul_b_q;

    always_comb begin
        tag_in       = '0;
        tag_in.valid = accept;
        if (accept) begin
            tag_in.id = win_id;
        end
    end

    // Depth LAT+1: one cycle for the operand register plus LAT in the multiplier.
    mult_tag_pipe #(
        .DEPTH (LAT + 1)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .clr     (flush),
        .in_tag  (tag_in),
        .out_tag (tag_out)
    );

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rsp_valid[i] = tag_out.valid && !flush && !rst && (tag_out.id == ID_W'(i));
        end
    end

    assign rsp_product = mul_product;

endmodule

// File: tb/tb_mult_rr_arbiter.sv
// Purpose : self-checking bench for mult_rr_arbiter with a behavioural model.
// Latency : model schedules each accepted op for cycle t+1+LAT.
// Backpressure: n/a.
module tb_mult_rr_arbiter;

    localparam int N_REQ = 2;
    localparam int LAT   = 2;
    localparam int NCYC  = 4096;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic [N_REQ-1:0] req_valid = '0;
    logic [4*N_REQ-1:0] req_a = '0;
    logic [4*N_REQ-1:0] req_b = '0;
    logic [N_REQ-1:0] req_grant;
    logic [3:0]       mul_a;
    logic [3:0]       mul_b;
    logic [7:0]       mul_product;
    logic [N_REQ-1:0] rsp_valid;
    logic [7:0]       rsp_product;

    always #5 clk = ~clk;

    mult_rr_arbiter #(
        .N_REQ (N_REQ),
        .LAT   (LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_grant   (req_grant),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_product (mul_product),
        .rsp_valid   (rsp_valid),
        .rsp_product (rsp_product)
    );

    // External multiplier: LAT register stages after the operand register.
    logic [7:0] mpipe [LAT] = '{default: 8'h00};
    always @(posedge clk) begin
        mpipe[0] <= {4'b0, mul_a} * {4'b0, mul_b};
        for (int i = 1; i < LAT; i++) begin
            mpipe[i] <= mpipe[i-1];
        end
    end
    assign mul_product = mpipe[LAT-1];

    // Behavioural model: expected response per absolute cycle number.
    bit exp_vld  [NCYC];
    int exp_id   [NCYC];
    int exp_prod [NCYC];
    int m_ptr = 0;
    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int obs_grant, obs_rsp, obs_prod;
    int g_log [8];
    int r_log [8];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, req);
        end
    endtask

    // One cycle: drive, compare DUT against the model, then advance the model.
    task automatic step(input logic r, input logic f, input logic [1:0] v,
                        input logic [7:0] a, input logic [7:0] b);
        int w;
        int eg;
        int er;
        int idx;
        @(negedge clk);
        rst = r; flush = f; req_valid = v; req_a = a; req_b = b;
        #1;
        w = -1;
        if (!r && !f && v != 2'b00) begin
            for (int k = 0; k < N_REQ; k++) begin
`ifdef MULT_ARB_FIXED_PRIO_EN
                idx = k;
`else
                idx = (m_ptr + k) % N_REQ;
`endif
                if (w < 0 && v[idx]) w = idx;
            end
        end
        eg = (w >= 0) ? (1 << w) : 0;
        chk("grant", int'(req_grant), eg);
        er = (!r && !f && exp_vld[cyc]) ? (1 << exp_id[cyc]) : 0;
        chk("rsp_valid", int'(rsp_valid), er);
        if (er != 0) chk("rsp_product", int'(rsp_product), exp_prod[cyc]);
        obs_grant = int'(req_grant);
        obs_rsp   = int'(rsp_valid);
        obs_prod  = int'(rsp_product);
        if (r || f) begin
            for (int d = cyc; d <= cyc + LAT + 1; d++) exp_vld[d] = 1'b0;
            if (r) m_ptr = 0;
        end else if (w >= 0) begin
            exp_vld[cyc+1+LAT]  = 1'b1;
            exp_id[cyc+1+LAT]   = w;
            exp_prod[cyc+1+LAT] = int'(a[4*w +: 4]) * int'(b[4*w +: 4]);
            m_ptr = (w + 1) % N_REQ;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 2'b00, 8'h00, 8'h00);
        step(1'b1, 1'b0, 2'b00, 8'h00, 8'h00);
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("reset_mul_a", int'(mul_a), 0);
        chk("reset_mul_b", int'(mul_b), 0);
        chk("reset_grant", obs_grant, 0);

        // Single op: 3*5 from requester 0
        step(1'b0, 1'b0, 2'b01, 8'h03, 8'h05);
        chk("single_grant", obs_grant, 1);
        idle(3);
        chk("single_rsp_valid", obs_rsp, 1);
        chk("single_product", obs_prod, 15);

        // Contention from reset
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 2'b11, 8'($urandom), 8'($urandom));
            g_log[i] = obs_grant;
            r_log[i] = obs_rsp;
        end
`ifdef MULT_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 6; i++) chk("fixed_grant", g_log[i], 1);
        chk("fixed_rsp3", r_log[3], 1);
        chk("fixed_rsp4", r_log[4], 1);
`else
        chk("rr_grant0", g_log[0], 1);
        chk("rr_grant1", g_log[1], 2);
        chk("rr_grant2", g_log[2], 1);
        chk("rr_grant3", g_log[3], 2);
        chk("rr_rsp3", r_log[3], 1);
        chk("rr_rsp4", r_log[4], 2);
`endif
        idle(4);

        // Max operands on requester 1
        do_reset();
        step(1'b0, 1'b0, 2'b10, 8'hF0, 8'hF0);
        idle(3);
        chk("max_rsp_valid", obs_rsp, 2);
        chk("max_product", obs_prod, 225);

        // Flush with ops in flight, request held through the flush cycle
        do_reset();
        step(1'b0, 1'b0, 2'b01, 8'h02, 8'h07);
        step(1'b0, 1'b0, 2'b10, 8'h40, 8'h40);
        step(1'b0, 1'b1, 2'b01, 8'h09, 8'h09);
        chk("flush_grant", obs_grant, 0);
        step(1'b0, 1'b0, 2'b01, 8'h09, 8'h09);
        chk("post_flush_grant", obs_grant, 1);
        chk("flush_rsp3", obs_rsp, 0);
        idle(1);
        chk("flush_rsp4", obs_rsp, 0);
        idle(1);
        chk("flush_rsp5", obs_rsp, 0);
        idle(1);
        chk("post_flush_rsp6", obs_rsp, 1);
        chk("post_flush_product", obs_prod, 81);

        // Reset mid-flight
        do_reset();
        step(1'b0, 1'b0, 2'b01, 8'h03, 8'h03);
        step(1'b1, 1'b0, 2'b11, 8'h33, 8'h33);
        chk("midrst_grant", obs_grant, 0);
        chk("midrst_rsp", obs_rsp, 0);
        step(1'b0, 1'b0, 2'b11, 8'h12, 8'h36);
        chk("after_rst_grant", obs_grant, 1);
        idle(1);
        chk("dropped_rsp3", obs_rsp, 0);
        idle(1);
        chk("dropped_rsp4", obs_rsp, 0);
        idle(1);
        chk("after_rst_rsp", obs_rsp, 1);
        chk("after_rst_product", obs_prod, 12);

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 19) == 0),
                 2'($urandom), 8'($urandom), 8'($urandom));
        end
        idle(LAT + 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
